// File: rtl/hazard_fwd_unit_if.sv
// Hazard/forwarding unit interface.
// Groups the decode-stage request signals and the unit's decisions.
//   master : decode-side control logic (drives id_*, ext_stall, kill_ex)
//   slave  : hazard_fwd_unit (drives stall, issue, fwd_*_sel, stall_cnt)
// Signals:
//   id_valid/id_rs1/id_rs1_used/id_rs2/id_rs2_used/id_rd/id_rd_we : ID instruction
//   id_is_load/id_is_branch/id_is_store : instruction class
//   ext_stall : whole-pipeline freeze, kill_ex : squash instruction entering EX
//   stall/issue : hazard decision, fwd_a_sel/fwd_b_sel : operand source selects
//   stall_cnt : saturating hazard-stall cycle count
interface hazard_fwd_unit_if #(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 3,
    parameter int CNT_W     = 16
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic              id_rs1_used;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_rd_we;
    logic              id_is_load;
    logic              id_is_branch;
    logic              id_is_store;
    logic              ext_stall;
    logic              kill_ex;
    logic              stall;
    logic              issue;
    logic [SEL_W-1:0]  fwd_a_sel;
    logic [SEL_W-1:0]  fwd_b_sel;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_rd_we,
               id_is_load, id_is_branch, id_is_store, ext_stall, kill_ex,
        input  stall, issue, fwd_a_sel, fwd_b_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_rd_we,
               id_is_load, id_is_branch, id_is_store, ext_stall, kill_ex,
        output stall, issue, fwd_a_sel, fwd_b_sel, stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard-detection and forwarding unit for the in-order integer pipeline.
// A shift-register tracker records the destination of each instruction in
// EX/MEM/WB; the ID instruction's sources are matched against it to decide
// issue/stall and which tracker entry (if any) supplies each operand.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears tracker and stall_cnt)
//   bus   : hazard_fwd_unit_if slave modport (ID request in, decisions out)
module hazard_fwd_unit #(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 3,
    parameter int LOAD_LAT  = 1,
    parameter int CNT_W     = 16
) (
    input logic               clk,
    input logic               rst_n,
    hazard_fwd_unit_if.slave  bus
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);
    localparam int IDX_W = SEL_W + 1;

    localparam logic [IDX_W-1:0] ZERO_C = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] ONE_C  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] LAT_C  = IDX_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

    typedef struct packed {
        logic             hit;
        logic             load;
        logic [IDX_W-1:0] k;
    } match_t;

    logic [FWD_DEPTH-1:0]             vld_q, vld_d;
    logic [FWD_DEPTH-1:0]             we_q, we_d;
    logic [FWD_DEPTH-1:0]             ld_q, ld_d;
    logic [FWD_DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;

    match_t           m_a_s, m_b_s;
    logic [IDX_W-1:0] req_a_s, req_b_s;
    logic             stall_s, issue_s;
    logic [SEL_W-1:0] sel_a_s, sel_b_s;

    // Youngest matching producer wins: scan oldest to youngest, overwriting.
    function automatic match_t find_match(
        input logic                             used,
        input logic [REG_AW-1:0]                src,
        input logic [FWD_DEPTH-1:0]             v,
        input logic [FWD_DEPTH-1:0]             w,
        input logic [FWD_DEPTH-1:0]             l,
        input logic [FWD_DEPTH-1:0][REG_AW-1:0] rd
    );
        match_t m;
        m = '{hit: 1'b0, load: 1'b0, k: {IDX_W{1'b0}}};
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (used && (src != {REG_AW{1'b0}}) && v[k] && w[k] && (rd[k] == src)) begin
                m.hit  = 1'b1;
                m.load = l[k];
                m.k    = IDX_W'(k);
            end else begin
                m = m;
            end
        end
        return m;
    endfunction

    // Source matching, readiness and the same-cycle issue/stall/select decision.
    always_comb begin
        m_a_s = find_match(bus.id_rs1_used, bus.id_rs1, vld_q, we_q, ld_q, rd_q);
        m_b_s = find_match(bus.id_rs2_used, bus.id_rs2, vld_q, we_q, ld_q, rd_q);

        // Branch operands are consumed one stage earlier, so need one more stage.
        req_a_s = (m_a_s.load ? LAT_C : ZERO_C) + (bus.id_is_branch ? ONE_C : ZERO_C);

        // Store data is consumed in MEM, one stage later; LOAD_LAT >= 1 keeps this >= 0.
        if (m_b_s.load) begin
            req_b_s = bus.id_is_store ? (LAT_C - ONE_C) : LAT_C;
        end else begin
            req_b_s = ZERO_C;
        end

        stall_s = bus.id_valid & ((m_a_s.hit & (m_a_s.k < req_a_s)) |
                                  (m_b_s.hit & (m_b_s.k < req_b_s)));
        issue_s = bus.id_valid & ~stall_s & ~bus.ext_stall;

        if (bus.id_valid && m_a_s.hit) begin
            sel_a_s = SEL_W'(m_a_s.k + ONE_C);
        end else begin
            sel_a_s = {SEL_W{1'b0}};
        end

        if (bus.id_valid && m_b_s.hit) begin
            sel_b_s = SEL_W'(m_b_s.k + ONE_C);
        end else begin
            sel_b_s = {SEL_W{1'b0}};
        end
    end

    // Tracker shift and stall counter next state; a freeze holds everything.
    always_comb begin
        vld_d = vld_q;
        we_d  = we_q;
        ld_d  = ld_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (!bus.ext_stall) begin
            for (int k = FWD_DEPTH - 1; k > 0; k--) begin
                vld_d[k] = vld_q[k-1];
                we_d[k]  = we_q[k-1];
                ld_d[k]  = ld_q[k-1];
                rd_d[k]  = rd_q[k-1];
            end
            // A stalled or killed instruction leaves a bubble in EX.
            vld_d[0] = issue_s & ~bus.kill_ex;
            we_d[0]  = bus.id_rd_we & (bus.id_rd != {REG_AW{1'b0}});
            ld_d[0]  = bus.id_is_load;
            rd_d[0]  = bus.id_rd;
            if (stall_s && (cnt_q != CNT_MAX_C)) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Tracker and counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= {FWD_DEPTH{1'b0}};
            we_q  <= {FWD_DEPTH{1'b0}};
            ld_q  <= {FWD_DEPTH{1'b0}};
            rd_q  <= {(FWD_DEPTH*REG_AW){1'b0}};
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            vld_q <= vld_d;
            we_q  <= we_d;
            ld_q  <= ld_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.stall     = stall_s;
    assign bus.issue     = issue_s;
    assign bus.fwd_a_sel = sel_a_s;
    assign bus.fwd_b_sel = sel_b_s;
    assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: the driver issues one ID request per
// cycle and queues the hand-computed response; a monitor on the falling edge
// pops and compares. A second instance with a 2-bit counter shares the
// stimulus to cover counter saturation.
module tb_hazard_fwd_unit;
    logic clk;
    logic rst_n;
    logic done;

    hazard_fwd_unit_if #(.REG_AW(5), .FWD_DEPTH(3), .CNT_W(16)) bus ();
    hazard_fwd_unit_if #(.REG_AW(5), .FWD_DEPTH(3), .CNT_W(2))  bus2 ();

    hazard_fwd_unit #(.REG_AW(5), .FWD_DEPTH(3), .LOAD_LAT(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    hazard_fwd_unit #(.REG_AW(5), .FWD_DEPTH(3), .LOAD_LAT(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
    );

    assign bus2.id_valid     = bus.id_valid;
    assign bus2.id_rs1       = bus.id_rs1;
    assign bus2.id_rs1_used  = bus.id_rs1_used;
    assign bus2.id_rs2       = bus.id_rs2;
    assign bus2.id_rs2_used  = bus.id_rs2_used;
    assign bus2.id_rd        = bus.id_rd;
    assign bus2.id_rd_we     = bus.id_rd_we;
    assign bus2.id_is_load   = bus.id_is_load;
    assign bus2.id_is_branch = bus.id_is_branch;
    assign bus2.id_is_store  = bus.id_is_store;
    assign bus2.ext_stall    = bus.ext_stall;
    assign bus2.kill_ex      = bus.kill_ex;

    typedef struct {
        logic        stall;
        logic        issue;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one ID request after the rising edge and queue its expected response.
    // rp pulses reset between the edges so the falling-edge check sees it asserted.
    task automatic step(input int v, input int rs1, input int u1, input int rs2, input int u2,
                        input int rd, input int we, input int ld, input int br, input int st,
                        input int xs, input int kl, input int rp,
                        input int es, input int ei, input int ea, input int eb, input int ec,
                        input string name);
        exp_t e;
        @(posedge clk);
        #1;
        bus.id_valid     = 1'(v);
        bus.id_rs1       = 5'(rs1);
        bus.id_rs1_used  = 1'(u1);
        bus.id_rs2       = 5'(rs2);
        bus.id_rs2_used  = 1'(u2);
        bus.id_rd        = 5'(rd);
        bus.id_rd_we     = 1'(we);
        bus.id_is_load   = 1'(ld);
        bus.id_is_branch = 1'(br);
        bus.id_is_store  = 1'(st);
        bus.ext_stall    = 1'(xs);
        bus.kill_ex      = 1'(kl);
        e.stall = 1'(es);
        e.issue = 1'(ei);
        e.a     = 2'(ea);
        e.b     = 2'(eb);
        e.cnt   = 16'(ec);
        e.cnt2  = (ec > 3) ? 2'd3 : 2'(ec);
        e.name  = name;
        exp_q.push_back(e);
        if (rp != 0) begin
            #2 rst_n = 1'b0;
            #4 rst_n = 1'b1;
        end
    endtask

    // Monitor: compare each queued expectation on the falling edge; close out when done.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests = n_tests + 1;
            if ({bus.stall, bus.issue, bus.fwd_a_sel, bus.fwd_b_sel, bus.stall_cnt, bus2.stall_cnt} !==
                {e.stall, e.issue, e.a, e.b, e.cnt, e.cnt2}) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got stall=%0d issue=%0d a=%0d b=%0d cnt=%0d cnt2=%0d, expected stall=%0d issue=%0d a=%0d b=%0d cnt=%0d cnt2=%0d",
                         e.name, bus.stall, bus.issue, bus.fwd_a_sel, bus.fwd_b_sel, bus.stall_cnt,
                         bus2.stall_cnt, e.stall, e.issue, e.a, e.b, e.cnt, e.cnt2);
            end
        end else if (done) begin
            n_tests = n_tests + 1;
            if (exp_q.size() != 0) begin
                n_fail = n_fail + 1;
                $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    // Watchdog against a stuck run.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    // Directed stimulus. Tracker contents after each edge noted as [EX, MEM, WB].
    initial begin
        n_tests = 0;
        n_fail  = 0;
        done    = 1'b0;
        rst_n   = 1'b0;
        bus.id_valid = 1'b0; bus.id_rs1 = 5'd0; bus.id_rs1_used = 1'b0;
        bus.id_rs2 = 5'd0; bus.id_rs2_used = 1'b0; bus.id_rd = 5'd0; bus.id_rd_we = 1'b0;
        bus.id_is_load = 1'b0; bus.id_is_branch = 1'b0; bus.id_is_store = 1'b0;
        bus.ext_stall = 1'b0; bus.kill_ex = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        //    v rs1 u1 rs2 u2 rd we ld br st xs kl rp | st is a  b  cnt
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, "reset_idle");
        step(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, "add_r3");          // [r3,-,-]
        step(1, 3, 1, 3, 1, 4, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 0, "alu_b2b");         // [r4,r3,-]
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, "nop");             // [-,r4,r3]
        step(1, 4, 1, 4, 1, 5, 1, 0, 0, 0, 0, 0, 0,   0, 1, 2, 2, 0, "alu_gap1");        // [r5,-,r4]
        step(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, "lw_r5");           // [r5L,r5,-]
        step(1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, "load_use_stall");  // [-,r5L,r5]
        step(1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 0, 0, 0,   0, 1, 2, 0, 1, "load_use_fwd");    // [r6,-,r5L]
        step(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, "lw_r5_again");     // [r5L,r6,-]
        step(1, 2, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 1, "store_relax");     // [sw,r5L,r6]
        step(1, 0, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, "lw_r7");           // [r7L,sw,r5L]
        step(1, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 1, 0, 1, "branch_stall1");   // [-,r7L,sw]
        step(1, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 2, 0, 2, "branch_stall2");   // [-,-,r7L]
        step(1, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 1, 3, 0, 3, "branch_fwd");      // [br,-,-]
        step(1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 3, "add_r2");          // [r2,br,-]
        step(1, 2, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 3, "addi_r2");         // [r2',r2,br]
        step(1, 2, 1, 2, 1, 8, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 3, "shadow");          // [r8,r2',r2]
        step(1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 3, "lw_r0");           // [r0L,r8,r2']
        step(1, 0, 1, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 3, "read_r0");         // [r9,r0L,r8]
        step(1, 8, 1, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0,  0, 1, 3, 0, 3, "lw_r10_fwd_wb");   // [r10L,r9,r0L]
        step(1, 10, 1, 9, 1, 11, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 2, 3, "frozen1");         // held
        step(1, 10, 1, 9, 1, 11, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 2, 3, "frozen2");         // held
        step(1, 10, 1, 9, 1, 11, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 2, 3, "frozen3");         // held
        step(1, 10, 1, 9, 1, 11, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 3, "unfrozen_stall");  // [-,r10L,r9]
        step(1, 10, 1, 9, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4, "unfrozen_fwd");    // [r11,-,r10L]
        step(1, 0, 1, 0, 0, 12, 1, 1, 0, 0, 0, 1, 0,  0, 1, 0, 0, 4, "lw_r12_killed");   // [-,r11,-]
        step(1, 12, 1, 12, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4, "after_kill");     // [r13,-,r11]
        step(1, 0, 1, 0, 0, 14, 1, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 4, "lw_r14");          // [r14L,r13,-]
        step(1, 14, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 4, "pre_reset_stall"); // [-,r14L,r13]
        step(1, 14, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,  0, 1, 0, 0, 0, "async_reset");     // [br,-,-]
        step(1, 0, 1, 0, 0, 20, 1, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, "lw_r20");          // [r20L,br,-]
        step(0, 20, 1, 20, 1, 21, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "invalid_gated");
        @(posedge clk);
        #1 done = 1'b1;
    end
endmodule
